// File: rtl/alu_result_display.sv
// Captures {cout, alu[3:0]} results into a small FIFO and shows the oldest one on a 7-segment digit.
// Optional macro ALU_DISP_SYNC_EN adds 2-flop synchronisers on res_valid/pop (with matched data delay).
module alu_result_display #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       res_valid_i,
  input  logic [3:0] res_data_i,
  input  logic       res_cout_i,
  input  logic       pop_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overflow_o
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [6:0]    SEG_DASH = 7'h40;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  logic       v_s, p_s, cout_s;
  logic [3:0] data_s;

`ifdef ALU_DISP_SYNC_EN
  logic       v_meta_q, v_sync_q, p_meta_q, p_sync_q;
  logic [3:0] data_d1_q, data_d2_q;
  logic       cout_d1_q, cout_d2_q;

  // Data rides a delay line of the same depth as the strobe synchroniser so it lines up with the event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_meta_q  <= 1'b0;
      v_sync_q  <= 1'b0;
      p_meta_q  <= 1'b0;
      p_sync_q  <= 1'b0;
      data_d1_q <= 4'h0;
      data_d2_q <= 4'h0;
      cout_d1_q <= 1'b0;
      cout_d2_q <= 1'b0;
    end else begin
      v_meta_q  <= res_valid_i;
      v_sync_q  <= v_meta_q;
      p_meta_q  <= pop_i;
      p_sync_q  <= p_meta_q;
      data_d1_q <= res_data_i;
      data_d2_q <= data_d1_q;
      cout_d1_q <= res_cout_i;
      cout_d2_q <= cout_d1_q;
    end
  end

  assign v_s    = v_sync_q;
  assign p_s    = p_sync_q;
  assign data_s = data_d2_q;
  assign cout_s = cout_d2_q;
`else
  assign v_s    = res_valid_i;
  assign p_s    = pop_i;
  assign data_s = res_data_i;
  assign cout_s = res_cout_i;
`endif

  logic          v_hist_q, p_hist_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          wr_en_s, push_ev_s, pop_ev_s, empty_s, full_s;
  logic [4:0]    mem_q [DEPTH];
  logic [4:0]    head_s;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d, empty_q, full_q;

  assign push_ev_s = v_s & ~v_hist_q;
  assign pop_ev_s  = p_s & ~p_hist_q;
  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == FULL_CNT);
  assign head_s    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en_s    = 1'b0;
    case ({push_ev_s, pop_ev_s})
      2'b10: begin
        if (!full_s) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
        end else begin
          overflow_d = 1'b1;
        end
      end
      2'b01: begin
        if (!empty_s) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          count_d  = count_q - CNT_ONE;
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      2'b11: begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        // An empty FIFO has nothing to pop, so the pair degenerates to a plain push.
        if (empty_s) begin
          count_d = count_q + CNT_ONE;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Display reflects the FIFO state committed on the previous edge, hence one extra cycle of latency.
  always_comb begin
    seg_d = SEG_DASH;
    dp_d  = 1'b0;
    if (empty_s) begin
      seg_d = SEG_DASH;
      dp_d  = 1'b0;
    end else begin
      seg_d = hex7(head_s[3:0]);
      dp_d  = head_s[4];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_hist_q   <= 1'b0;
      p_hist_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      seg_q      <= SEG_DASH;
      dp_q       <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      v_hist_q   <= v_s;
      p_hist_q   <= p_s;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      empty_q    <= empty_s;
      full_q     <= full_s;
    end
  end

  // Storage needs no reset: count gates every read, so stale entries are never shown.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {cout_s, data_s};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign seg_o      = seg_q;
  assign dp_o       = dp_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: a queue model tracks stored results and each test compares the display.
module tb_alu_result_display;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_cout;
  logic       pop;
  logic [6:0] seg;
  logic       dp, empty, full, overflow;

  int checks   = 0;
  int failures = 0;

  logic [4:0] sb_q[$];
  logic       ovf_m;
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  alu_result_display #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk_i(clk), .rst_i(rst), .res_valid_i(res_valid), .res_data_i(res_data),
    .res_cout_i(res_cout), .pop_i(pop), .seg_o(seg), .dp_o(dp), .empty_o(empty),
    .full_o(full), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg();
    if (sb_q.size() == 0) return 7'h40;
    else return hex_tab[sb_q[0][3:0]];
  endfunction

  function automatic logic exp_dp();
    if (sb_q.size() == 0) return 1'b0;
    else return sb_q[0][4];
  endfunction

  // Enough cycles for the optional synchroniser plus the display register.
  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  task automatic do_push(input logic [3:0] d, input logic c);
    @(negedge clk);
    res_valid = 1'b1; res_data = d; res_cout = c;
    if (sb_q.size() < DEPTH) sb_q.push_back({c, d});
    else ovf_m = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    settle();
  endtask

  task automatic do_pop();
    @(negedge clk);
    pop = 1'b1;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    @(negedge clk);
    pop = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb_q.delete(); ovf_m = 1'b0;
    @(negedge clk);
    checks++; if (seg !== 7'h40) begin failures++; $display("FAIL reset_seg got=%h exp=40", seg); end
    checks++; if (dp !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=0", dp); end
    checks++; if ({empty, full, overflow} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {empty, full, overflow}); end
  endtask

  task automatic test_single();
    do_push(4'h5, 1'b1);
    checks++; if (seg !== 7'h6D || seg !== exp_seg()) begin failures++; $display("FAIL single_seg got=%h exp=6d", seg); end
    checks++; if ({dp, empty} !== 2'b10) begin failures++; $display("FAIL single_dp_empty got=%b exp=10", {dp, empty}); end
    do_pop();
    checks++; if (seg !== 7'h40 || empty !== 1'b1) begin failures++; $display("FAIL single_pop got=%h/%b exp=40/1", seg, empty); end
  endtask

  task automatic test_hold();
    @(negedge clk);
    res_valid = 1'b1; res_data = 4'h3; res_cout = 1'b0;
    sb_q.push_back({1'b0, 4'h3});
    repeat (10) @(negedge clk);
    res_valid = 1'b0;
    settle();
    checks++; if (seg !== 7'h4F || dp !== exp_dp()) begin failures++; $display("FAIL hold_seg got=%h exp=4f", seg); end
    do_pop();
    checks++; if (empty !== 1'b1 || seg !== exp_seg()) begin failures++; $display("FAIL hold_once got empty=%b seg=%h exp empty=1 seg=40", empty, seg); end
  endtask

  task automatic test_overflow();
    logic [6:0] want [5] = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h40};
    do_push(4'hA, 1'b0); do_push(4'hB, 1'b1); do_push(4'hC, 1'b0); do_push(4'hD, 1'b1);
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got full=%b ovf=%b exp 1/0", full, overflow); end
    do_push(4'hE, 1'b0);
    checks++; if (full !== 1'b1 || overflow !== ovf_m || overflow !== 1'b1) begin failures++; $display("FAIL ovf_drop got full=%b ovf=%b exp 1/1", full, overflow); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (seg !== want[i] || seg !== exp_seg() || dp !== exp_dp()) begin
        failures++; $display("FAIL ovf_pop%0d got=%h/%b exp=%h/%b", i, seg, dp, want[i], exp_dp());
      end
      do_pop();
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] want [4] = '{7'h5B, 7'h4F, 7'h66, 7'h6F};
    do_push(4'h1, 1'b0); do_push(4'h2, 1'b0); do_push(4'h3, 1'b1); do_push(4'h4, 1'b0);
    @(negedge clk);
    res_valid = 1'b1; res_data = 4'h9; res_cout = 1'b0; pop = 1'b1;
    void'(sb_q.pop_front()); sb_q.push_back({1'b0, 4'h9});
    @(negedge clk);
    res_valid = 1'b0; pop = 1'b0;
    settle();
    checks++; if (full !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL b2b_full got full=%b empty=%b exp 1/0", full, empty); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seg !== want[i] || seg !== exp_seg() || dp !== exp_dp()) begin
        failures++; $display("FAIL b2b_pop%0d got=%h/%b exp=%h/%b", i, seg, dp, want[i], exp_dp());
      end
      do_pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_mid_reset();
    do_push(4'h6, 1'b1); do_push(4'h8, 1'b0);
    checks++; if (seg !== 7'h7D || dp !== 1'b1) begin failures++; $display("FAIL mid_pre got=%h/%b exp=7d/1", seg, dp); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete(); ovf_m = 1'b0;
    checks++; if ({seg, dp, empty, full, overflow} !== {7'h40, 4'b0100}) begin
      failures++; $display("FAIL mid_reset got seg=%h dp=%b e=%b f=%b o=%b exp 40/0/1/0/0", seg, dp, empty, full, overflow);
    end
    do_push(4'h7, 1'b0);
    checks++; if (seg !== 7'h07 || dp !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL mid_push got=%h/%b exp=07/0", seg, dp); end
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_data = 4'h0; res_cout = 1'b0; pop = 1'b0; ovf_m = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
